// File: rtl/neuron_mac_pkg.sv
// Shared types and sizing helpers for the neuron MAC accumulator.
package neuron_mac_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FINAL = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Full-width product sum plus growth for n_inputs terms and a sign guard bit.
    function automatic int acc_w(input int data_w, input int n_inputs);
        return 2 * data_w + $clog2(n_inputs) + 1;
    endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// Bias add, arithmetic rescale and resize of the accumulator to the output Q format.
// NEURON_MAC_SAT_EN selects saturation; otherwise the result wraps to DATA_W bits.
module neuron_mac_sat #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int ACC_W  = 19
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] z
);

    localparam int SUM_W = ACC_W + 1;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [SUM_W-1:0] Z_MAX = SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] Z_MIN = -Z_MAX - SUM_W'(1);
`endif

    always_comb begin
        sum     = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_W);
        // Arithmetic shift floors toward minus infinity; no rounding term.
        shifted = sum >>> FRAC_W;
`ifdef NEURON_MAC_SAT_EN
        if (shifted > Z_MAX) begin
            z = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (shifted < Z_MIN) begin
            z = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            z = DATA_W'(shifted);
        end
`else
        z = DATA_W'(shifted);
`endif
    end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Multiply-accumulate of N_INPUTS (x, w) pairs plus bias, producing one pre-activation value.
// Optional macro NEURON_MAC_SAT_EN makes the final resize saturate instead of wrap.
module neuron_mac_accumulator
    import neuron_mac_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int N_INPUTS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     z_valid,
    input  logic                     z_ready,
    output logic signed [DATA_W-1:0] z_value
);

    localparam int ACC_W = acc_w(DATA_W, N_INPUTS);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    state_t                    state, state_nxt;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]  z_next;
    logic                      xfer;

    always_comb begin
        prod = x_data * w_data;
    end

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        xfer      = 1'b0;
        case (state)
            ACC: begin
                x_ready = 1'b1;
                xfer    = x_valid;
                if (x_valid && cnt == CNT_LAST) begin
                    state_nxt = FINAL;
                end
            end
            FINAL:   state_nxt = OUT;
            OUT:     if (z_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            z_valid <= 1'b0;
            z_value <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (xfer) begin
                        acc <= acc + ACC_W'(prod);
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FINAL: begin
                    z_value <= z_next;
                    z_valid <= 1'b1;
                end
                OUT: begin
                    if (z_ready) begin
                        z_valid <= 1'b0;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    neuron_mac_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc  (acc),
        .bias (bias),
        .z    (z_next)
    );

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Self-checking bench for neuron_mac_accumulator (N_INPUTS=4 main instance, N_INPUTS=1 boundary instance).
module tb_neuron_mac_accumulator;

    localparam int DW = 8;
    localparam int FW = 4;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                 x_valid = 1'b0, x_ready, z_valid, z_ready = 1'b0;
    logic signed [DW-1:0] x_data = '0, w_data = '0, bias = '0, z_value;

    logic                 x_valid1 = 1'b0, x_ready1, z_valid1, z_ready1 = 1'b0;
    logic signed [DW-1:0] x_data1 = '0, w_data1 = '0, bias1 = '0, z_value1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic signed [DW-1:0] xs [NI];
    logic signed [DW-1:0] ws [NI];

    neuron_mac_accumulator #(.DATA_W(DW), .FRAC_W(FW), .N_INPUTS(NI)) dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready),
        .x_data(x_data), .w_data(w_data), .bias(bias),
        .z_valid(z_valid), .z_ready(z_ready), .z_value(z_value)
    );

    neuron_mac_accumulator #(.DATA_W(DW), .FRAC_W(FW), .N_INPUTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid1), .x_ready(x_ready1),
        .x_data(x_data1), .w_data(w_data1), .bias(bias1),
        .z_valid(z_valid1), .z_ready(z_ready1), .z_value(z_value1)
    );

    // Reference: exact integer sum, add scaled bias, floor-divide by 2^FW, then clamp or wrap.
    function automatic logic signed [DW-1:0] model(input int n, input logic signed [DW-1:0] b);
        longint s;
        longint lo, hi;
        logic [63:0] raw;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'(xs[i]) * longint'(ws[i]);
        s = (s + longint'(b) * (64'sd1 <<< FW)) >>> FW;
        lo = -(64'sd1 <<< (DW - 1));
        hi = (64'sd1 <<< (DW - 1)) - 1;
`ifdef NEURON_MAC_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`endif
        raw = s;
        return raw[DW-1:0];
    endfunction

    task automatic run_eval(input int n, input bit hold_valid, input bit gaps,
                            output logic signed [DW-1:0] z, output int lat, output bit to);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                x_valid = 1'b0;
                @(posedge clk); #1;
            end
            x_valid = 1'b1;
            x_data  = xs[i];
            w_data  = ws[i];
            @(posedge clk); #1;
        end
        x_valid = hold_valid;
        x_data  = DW'($urandom);
        w_data  = DW'($urandom);
        lat = 1;
        while (!z_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !z_valid;
        z  = z_value;
    endtask

    task automatic consume();
        z_ready = 1'b1;
        @(posedge clk); #1;
        z_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        chk_cnt++; if (z_valid !== 1'b0) $display("FAIL reset_z_valid: got %b expected 0", z_valid); else pass_cnt++;
        chk_cnt++; if (z_value !== 8'sd0) $display("FAIL reset_z_value: got %0d expected 0", z_value); else pass_cnt++;
        chk_cnt++; if (x_ready !== 1'b1) $display("FAIL reset_x_ready: got %b expected 1", x_ready); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic signed [DW-1:0] z; int lat; bit to;
        for (int i = 0; i < NI; i++) begin xs[i] = 8'sd16; ws[i] = 8'sd16; end
        bias = 8'sd0;
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to) $display("FAIL basic_timeout: z_valid never rose"); else pass_cnt++;
        chk_cnt++; if (z !== 8'sd64) $display("FAIL basic_z: got %0d expected 64", z); else pass_cnt++;
        // Edges counted from the accepting edge inclusive.
        chk_cnt++; if (lat !== 2) $display("FAIL basic_latency: got %0d edges expected 2", lat); else pass_cnt++;
        consume();
    endtask

    task automatic test_saturation();
        logic signed [DW-1:0] z, exp_z; int lat; bit to;
        for (int i = 0; i < NI; i++) begin xs[i] = 8'sd127; ws[i] = 8'sd127; end
        bias = 8'sd0;
`ifdef NEURON_MAC_SAT_EN
        exp_z = 8'sd127;
`else
        exp_z = -8'sd64;
`endif
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== exp_z) $display("FAIL sat_pos: got %0d expected %0d", z, exp_z); else pass_cnt++;
        consume();
        for (int i = 0; i < NI; i++) begin xs[i] = -8'sd128; ws[i] = 8'sd127; end
        exp_z = model(NI, bias);
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== exp_z) $display("FAIL sat_neg: got %0d expected %0d", z, exp_z); else pass_cnt++;
        consume();
    endtask

    task automatic test_bias_floor();
        logic signed [DW-1:0] z; int lat; bit to;
        for (int i = 0; i < NI; i++) begin xs[i] = 8'sd0; ws[i] = DW'($urandom); end
        bias = -8'sd8;
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== -8'sd8) $display("FAIL bias_neg: got %0d expected -8", z); else pass_cnt++;
        consume();
        bias = 8'sd0;
    endtask

    task automatic test_single_input();
        int k;
        x_valid1 = 1'b1; x_data1 = -8'sd1; w_data1 = 8'sd1; bias1 = 8'sd0;
        @(posedge clk); #1;
        x_valid1 = 1'b0;
        chk_cnt++; if (x_ready1 !== 1'b0 || z_valid1 !== 1'b0)
            $display("FAIL n1_final: x_ready=%b z_valid=%b expected 0 0", x_ready1, z_valid1); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (z_valid1 !== 1'b1 || z_value1 !== -8'sd1)
            $display("FAIL n1_floor_neg: z_valid=%b z=%0d expected 1 -1", z_valid1, z_value1); else pass_cnt++;
        z_ready1 = 1'b1; @(posedge clk); #1; z_ready1 = 1'b0;
        x_valid1 = 1'b1; x_data1 = 8'sd1; w_data1 = 8'sd1;
        @(posedge clk); #1;
        x_valid1 = 1'b0;
        k = 0;
        while (!z_valid1 && k < 8) begin @(posedge clk); #1; k++; end
        chk_cnt++; if (z_valid1 !== 1'b1 || z_value1 !== 8'sd0)
            $display("FAIL n1_floor_pos: z_valid=%b z=%0d expected 1 0", z_valid1, z_value1); else pass_cnt++;
        z_ready1 = 1'b1; @(posedge clk); #1; z_ready1 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic signed [DW-1:0] z, exp_z; int lat; bit to;
        for (int i = 0; i < NI; i++) begin xs[i] = DW'($urandom); ws[i] = DW'($urandom); end
        bias  = DW'($urandom);
        exp_z = model(NI, bias);
        run_eval(NI, 1'b1, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== exp_z) $display("FAIL bp_value: got %0d expected %0d", z, exp_z); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            x_data = DW'($urandom);
            @(posedge clk); #1;
            chk_cnt++; if (z_valid !== 1'b1 || z_value !== exp_z || x_ready !== 1'b0)
                $display("FAIL bp_hold: z_valid=%b z=%0d x_ready=%b expected 1 %0d 0", z_valid, z_value, x_ready, exp_z);
            else pass_cnt++;
        end
        z_ready = 1'b1; #1;
        chk_cnt++; if (x_ready !== 1'b0) $display("FAIL bp_no_overlap: x_ready=%b expected 0", x_ready); else pass_cnt++;
        @(posedge clk); #1;
        z_ready = 1'b0; x_valid = 1'b0;
        chk_cnt++; if (x_ready !== 1'b1 || z_valid !== 1'b0)
            $display("FAIL bp_release: x_ready=%b z_valid=%b expected 1 0", x_ready, z_valid); else pass_cnt++;
        for (int i = 0; i < NI; i++) begin xs[i] = DW'($urandom); ws[i] = DW'($urandom); end
        exp_z = model(NI, bias);
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== exp_z) $display("FAIL bp_next_eval: got %0d expected %0d", z, exp_z); else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] z; int lat; bit to;
        for (int i = 0; i < 2; i++) begin
            x_valid = 1'b1; x_data = 8'sd127; w_data = 8'sd127;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (x_ready !== 1'b1 || z_valid !== 1'b0)
            $display("FAIL rst_mid_async: x_ready=%b z_valid=%b expected 1 0", x_ready, z_valid); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_cnt++; if (z_valid !== 1'b0) $display("FAIL rst_mid_hold: z_valid=%b expected 0", z_valid); else pass_cnt++;
        end
        x_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin xs[i] = 8'sd16; ws[i] = 8'sd16; end
        bias = 8'sd0;
        run_eval(NI, 1'b0, 1'b0, z, lat, to);
        chk_cnt++; if (to || z !== 8'sd64) $display("FAIL rst_mid_restart: got %0d expected 64", z); else pass_cnt++;
        consume();
    endtask

    task automatic test_random();
        logic signed [DW-1:0] z, exp_z; int lat; bit to;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NI; i++) begin xs[i] = DW'($urandom); ws[i] = DW'($urandom); end
            bias  = DW'($urandom);
            exp_z = model(NI, bias);
            run_eval(NI, 1'($urandom_range(0, 1)), 1'b1, z, lat, to);
            chk_cnt++; if (to || z !== exp_z) $display("FAIL random_%0d: got %0d expected %0d", r, z, exp_z); else pass_cnt++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
            x_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_bias_floor();
        test_single_input();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/neuron_mac_accumulator.md
NEURON_MAC_ACCUMULATOR -- requirements
Module: neuron_mac_accumulator

Interface
REQ-001 Parameter DATA_W, default 8: width of inputs, weights, bias and result (signed Q(DATA_W-FRAC_W).FRAC_W).
REQ-002 Parameter FRAC_W, default 4: fractional bits of every DATA_W operand.
REQ-003 Parameter N_INPUTS, default 4, legal range 1..256: number of (x, w) pairs accumulated per neuron evaluation.
REQ-004 clk  in  1  single clock; all state on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 x_valid  in  1  upstream offers one (x_data, w_data) pair.
REQ-007 x_ready  out  1  block accepts a pair this cycle; a transfer occurs when x_valid && x_ready.
REQ-008 x_data  in  DATA_W  signed input activation.
REQ-009 w_data  in  DATA_W  signed weight paired with x_data.
REQ-010 bias  in  DATA_W  signed neuron bias; sampled only in FINAL.
REQ-011 z_valid  out  1  z_value holds a completed result.
REQ-012 z_ready  in  1  downstream activation stage consumes z_value.
REQ-013 z_value  out  DATA_W  signed pre-activation sum, same Q format as inputs; feeds the LUT/interpolator activation stage directly.

Function
REQ-014 States SHALL be ACC, FINAL, OUT; x_ready SHALL be 1 only in ACC, combinationally from state.
REQ-015 In ACC, each transfer SHALL add the full signed product x_data*w_data (2*DATA_W bits) to acc and increment cnt.
REQ-016 acc SHALL be ACC_W = 2*DATA_W + clog2(N_INPUTS) + 1 bits signed; no overflow is possible inside acc.
REQ-017 The transfer with cnt == N_INPUTS-1 SHALL move ACC->FINAL on the same edge (N_INPUTS=1: first transfer).
REQ-018 FINAL SHALL last exactly one cycle: z_value <= resize((acc + (bias <<< FRAC_W)) >>> FRAC_W), z_valid <= 1, state -> OUT.
REQ-019 Shift SHALL be arithmetic (floor toward minus infinity); no rounding.
REQ-020 Latency: z_valid SHALL rise 2 edges after the edge accepting the last pair.
REQ-021 In OUT, z_value and z_valid SHALL hold stable until z_valid && z_ready; on that edge z_valid <= 0, acc <= 0, cnt <= 0, state -> ACC.
REQ-022 x_valid asserted in FINAL or OUT SHALL be ignored (no transfer, no state change).
REQ-023 Simultaneous z_ready with state change: x_ready SHALL reassert the cycle after the handshake, not on it (no same-cycle overlap).

Reset
REQ-024 rst_n low SHALL, asynchronously and at any state, force state=ACC, acc=0, cnt=0, z_valid=0, z_value=0; x_ready therefore 1.
REQ-025 Reset mid-accumulation SHALL discard all partial pairs; the next evaluation starts at cnt=0.

Configuration
REQ-026 Macro NEURON_MAC_SAT_EN defined: the resize in REQ-018 SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 Macro NEURON_MAC_SAT_EN undefined: the resize SHALL keep the low DATA_W bits (two's-complement wrap).

Structure
REQ-028 Package neuron_mac_pkg SHALL hold the state enum (ACC, FINAL, OUT) and the ACC_W width function.
REQ-029 Sub-module neuron_mac_sat SHALL implement bias add, arithmetic shift and the macro-selected saturate/wrap, purely combinationally.

Verification
REQ-030 Basic: 4 pairs x=16, w=16, bias=0 -> z_value=64 (4.0), z_valid 2 edges after 4th transfer.
REQ-031 Saturation: 4 pairs x=127, w=127 -> z_value=127 with NEURON_MAC_SAT_EN, z_value=-64 (0xC0) without; 4 pairs x=-128, w=127 with macro -> -128.
REQ-032 Bias/floor: 4 pairs x=0, bias=-8 -> z_value=-8; 1 pair x=1, w=1, bias=0 (N_INPUTS=1 build) -> z_value=0 (floor of 1/16).
REQ-033 Backpressure: hold z_ready=0 for 5 cycles with x_valid=1 -> z_value/z_valid stable, x_ready=0, acc unchanged; release -> next evaluation correct.
REQ-034 Reset mid-operation: 2 pairs of 127*127, drop rst_n mid-cycle, then 4 pairs x=16, w=16 -> z_value=64, z_valid=0 throughout reset.
